// File: rtl/rkey_sched_ctrl.sv
// rtl/rkey_sched_ctrl.sv - round key cache controller for AES-192 decryption
// Expands each loaded key once, caches NR+1 round keys, and serves them last-first per block.
module rkey_sched_ctrl #(
  parameter int NR = 12,
  parameter int KW = 192,
  parameter int BW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_in_vld,
  output logic          key_in_rdy,
  output logic [KW-1:0] ke_kt,
  output logic          ke_kt_vld,
  input  logic          ke_kt_rdy,
  input  logic [BW-1:0] ke_rkey,
  input  logic          ke_rkey_vld,
  input  logic          ke_rkey_last,
  input  logic          rk_start,
  input  logic          rk_next,
  output logic [BW-1:0] rk_out,
  output logic          rk_out_vld,
  output logic          rk_out_last,
  output logic          key_ready,
  output logic          key_err
);

  localparam int            PW       = $clog2(NR + 2);
  localparam logic [PW-1:0] LAST_IDX = PW'(NR);
  localparam logic [PW-1:0] PTR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] cache [0:NR];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          busy;

  logic key_acc;
  logic cap_win;
  logic cap_wr;
  logic cap_last;
  logic last_ok;
  logic serve_start;

  assign key_in_rdy  = (state == IDLE || state == READY) && !busy;
  assign key_acc     = key_in_vld && key_in_rdy;
  // Round key 0 arrives in the LOAD handshake cycle, so LOAD is part of the capture window.
  assign cap_win     = (state == LOAD) || (state == CAPTURE);
  assign cap_wr      = cap_win && ke_rkey_vld;
  assign cap_last    = cap_wr && ke_rkey_last;
  assign last_ok     = (wr_ptr == LAST_IDX);
  // A key accepted in the same cycle invalidates the cache, so it wins over rk_start.
  assign serve_start = (state == READY) && rk_start && !key_acc;

  assign ke_kt_vld   = (state == LOAD);
  assign rk_out_vld  = busy;
  assign rk_out_last = busy && (rd_ptr == '0);
  assign rk_out      = busy ? cache[rd_ptr] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (key_acc) state_nx = LOAD;
      end
      LOAD, CAPTURE: begin
        if (cap_last) state_nx = last_ok ? READY : IDLE;
        else if (state == LOAD && ke_kt_rdy) state_nx = CAPTURE;
      end
      READY: begin
        if (key_acc) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ke_kt     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (key_acc) begin
        ke_kt     <= key_in;
        wr_ptr    <= '0;
        key_ready <= 1'b0;
        key_err   <= 1'b0;
      end else if (cap_wr && wr_ptr != PTR_MAX) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (cap_last) begin
        if (last_ok) key_ready <= 1'b1;
        else         key_err   <= 1'b1;
      end
      if (serve_start) begin
        busy   <= 1'b1;
        rd_ptr <= LAST_IDX;
      end else if (rk_next && busy) begin
        if (rd_ptr != '0) rd_ptr <= rd_ptr - PW'(1);
        else              busy   <= 1'b0;
      end
    end
  end

  // Overlong expander runs saturate wr_ptr and are not stored.
  always_ff @(posedge clk) begin
    if (cap_wr && wr_ptr <= LAST_IDX) cache[wr_ptr] <= ke_rkey;
  end

endmodule

// File: tb/tb_rkey_sched_ctrl.sv
// tb/tb_rkey_sched_ctrl.sv - self-checking bench for rkey_sched_ctrl
// Expander is modelled by a real AES-192 key schedule; serving is checked against a position model.
module tb_rkey_sched_ctrl;
  localparam int NR = 12;
  localparam int KW = 192;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [KW-1:0] key_in;
  logic          key_in_vld;
  logic          key_in_rdy;
  logic [KW-1:0] ke_kt;
  logic          ke_kt_vld;
  logic          ke_kt_rdy;
  logic [BW-1:0] ke_rkey;
  logic          ke_rkey_vld;
  logic          ke_rkey_last;
  logic          rk_start;
  logic          rk_next;
  logic [BW-1:0] rk_out;
  logic          rk_out_vld;
  logic          rk_out_last;
  logic          key_ready;
  logic          key_err;

  always #5 clk = ~clk;

  rkey_sched_ctrl #(.NR(NR), .KW(KW), .BW(BW)) dut (
    .clk(clk), .rst(rst),
    .key_in(key_in), .key_in_vld(key_in_vld), .key_in_rdy(key_in_rdy),
    .ke_kt(ke_kt), .ke_kt_vld(ke_kt_vld), .ke_kt_rdy(ke_kt_rdy),
    .ke_rkey(ke_rkey), .ke_rkey_vld(ke_rkey_vld), .ke_rkey_last(ke_rkey_last),
    .rk_start(rk_start), .rk_next(rk_next),
    .rk_out(rk_out), .rk_out_vld(rk_out_vld), .rk_out_last(rk_out_last),
    .key_ready(key_ready), .key_err(key_err)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0]    sb [256];
  logic [BW-1:0] sched [NR+1];

  typedef struct {
    bit start;
    bit next;
    bit kv;
    bit exp_vld;
    bit exp_last;
    int exp_idx;
    bit exp_rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [KW-1:0] key);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[KW-1-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r <= NR; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [KW-1:0] key, input int gap, input int nkeys, input bit rand_gaps);
    expand(key);
    chk("load_rdy", key_in_rdy, 1);
    key_in = key;
    key_in_vld = 1'b1;
    tick();
    key_in_vld = 1'b0;
    chk("load_ke_kt", ke_kt, key);
    chk("load_ready_clr", key_ready, 0);
    for (int g = 0; g < gap; g++) begin
      chk("load_kt_vld_hold", ke_kt_vld, 1);
      tick();
    end
    chk("load_kt_vld", ke_kt_vld, 1);
    ke_kt_rdy = 1'b1;
    ke_rkey = sched[0];
    ke_rkey_vld = 1'b1;
    ke_rkey_last = (nkeys == 1);
    tick();
    ke_kt_rdy = 1'b0;
    chk("load_kt_vld_drop", ke_kt_vld, 0);
    for (int k = 1; k < nkeys; k++) begin
      ke_rkey_vld = 1'b0;
      ke_rkey_last = 1'b0;
      if (rand_gaps) repeat ($urandom_range(0, 2)) tick();
      ke_rkey = sched[k];
      ke_rkey_vld = 1'b1;
      ke_rkey_last = (k == nkeys - 1);
      tick();
    end
    ke_rkey_vld = 1'b0;
    ke_rkey_last = 1'b0;
    ke_rkey = '0;
  endtask

  task automatic serve_block(input string tag);
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    for (int r = NR; r >= 0; r--) begin
      chk({tag, "_vld"}, rk_out_vld, 1);
      chk({tag, "_key"}, rk_out, sched[r]);
      chk({tag, "_last"}, rk_out_last, r == 0);
      chk({tag, "_no_kt_vld"}, ke_kt_vld, 0);
      rk_next = 1'b1;
      tick();
      rk_next = 1'b0;
    end
    chk({tag, "_end_vld"}, rk_out_vld, 0);
    chk({tag, "_end_out"}, rk_out, 0);
    chk({tag, "_end_rdy"}, key_in_rdy, 1);
  endtask

  function automatic vec_t mk(bit s, bit n, bit kv, bit v, bit l, int idx, bit rdy);
    vec_t e;
    e.start = s; e.next = n; e.kv = kv; e.exp_vld = v; e.exp_last = l; e.exp_idx = idx; e.exp_rdy = rdy;
    return e;
  endfunction

  logic [KW-1:0] kc;
  logic [KW-1:0] kr;
  logic [BW-1:0] exp_out;
  bit            active;
  int            idx;
  bit            st;
  bit            nx;

  initial begin
    kc = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    rst = 1'b0;
    key_in = '0; key_in_vld = 1'b0; ke_kt_rdy = 1'b0;
    ke_rkey = '0; ke_rkey_vld = 1'b0; ke_rkey_last = 1'b0;
    rk_start = 1'b0; rk_next = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_kt_vld", ke_kt_vld, 0);
    chk("rst_out_vld", rk_out_vld, 0);
    chk("rst_out_last", rk_out_last, 0);
    chk("rst_out", rk_out, 0);
    chk("rst_in_rdy", key_in_rdy, 1);
    rst = 1'b1;
    tick();

    // FIPS-197 C.2 key, first block served by hand against known round keys
    load_key(kc, 2, 13, 1'b0);
    chk("c2_key_ready", key_ready, 1);
    chk("c2_key_err", key_err, 0);
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    chk("c2_first_vld", rk_out_vld, 1);
    chk("c2_first_key", rk_out, 128'ha4970a331a78dc09c418c271e3a41d5d);
    repeat (NR) begin
      rk_next = 1'b1;
      tick();
    end
    rk_next = 1'b0;
    chk("c2_final_key", rk_out, 128'h000102030405060708090a0b0c0d0e0f);
    chk("c2_final_last", rk_out_last, 1);
    rk_next = 1'b1;
    tick();
    rk_next = 1'b0;
    chk("c2_done_vld", rk_out_vld, 0);
    chk("c2_done_idle", key_in_rdy, 1);

    serve_block("blk2");
    serve_block("blk3");
    chk("blk3_key_ready", key_ready, 1);

    // restart mid-block with key_in_vld held throughout
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, NR, 0));
    for (int i = NR - 1; i >= NR - 5; i--) tbl.push_back(mk(0, 1, 1, 1, 0, i, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, NR, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, NR, 0));
    for (int i = NR - 1; i >= 0; i--) tbl.push_back(mk(0, 1, 1, 1, i == 0, i, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_in = kr;
    foreach (tbl[i]) begin
      rk_start = tbl[i].start;
      rk_next = tbl[i].next;
      key_in_vld = tbl[i].kv;
      tick();
      exp_out = tbl[i].exp_vld ? sched[tbl[i].exp_idx] : '0;
      chk($sformatf("tbl%0d_vld", i), rk_out_vld, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_last", i), rk_out_last, tbl[i].exp_last);
      chk($sformatf("tbl%0d_out", i), rk_out, exp_out);
      chk($sformatf("tbl%0d_rdy", i), key_in_rdy, tbl[i].exp_rdy);
    end
    key_in_vld = 1'b0;
    rk_start = 1'b0;
    rk_next = 1'b0;
    chk("tbl_key_kept", key_ready, 1);
    chk("tbl_no_load", ke_kt_vld, 0);

    // short expander run: 11 keys
    load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 0, 11, 1'b1);
    chk("err_key_err", key_err, 1);
    chk("err_key_ready", key_ready, 0);
    chk("err_idle_rdy", key_in_rdy, 1);
    chk("err_kt_vld", ke_kt_vld, 0);
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    chk("err_start_ignored", rk_out_vld, 0);
    tick();
    chk("err_sticky", key_err, 1);

    // reset during CAPTURE while the expander keeps running
    expand(kc);
    key_in = kc;
    key_in_vld = 1'b1;
    tick();
    key_in_vld = 1'b0;
    ke_kt_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ke_rkey = sched[k];
      ke_rkey_vld = 1'b1;
      tick();
      ke_kt_rdy = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("arst_kt_vld", ke_kt_vld, 0);
    chk("arst_key_ready", key_ready, 0);
    chk("arst_key_err", key_err, 0);
    chk("arst_out_vld", rk_out_vld, 0);
    chk("arst_out", rk_out, 0);
    chk("arst_in_rdy", key_in_rdy, 1);
    tick();
    rst = 1'b1;
    for (int k = 4; k <= NR + 3; k++) begin
      ke_rkey = sched[k % (NR + 1)];
      ke_rkey_vld = 1'b1;
      ke_rkey_last = (k % (NR + 1) == NR);
      tick();
      chk($sformatf("stray%0d_kt_vld", k), ke_kt_vld, 0);
      chk($sformatf("stray%0d_ready", k), key_ready, 0);
      chk($sformatf("stray%0d_err", k), key_err, 0);
    end
    ke_rkey_vld = 1'b0;
    ke_rkey_last = 1'b0;
    load_key(kc, 3, 13, 1'b1);
    chk("rst_reload_ready", key_ready, 1);
    chk("rst_reload_err", key_err, 0);
    serve_block("after_rst");

    // random keys with random start/next traffic
    for (int it = 0; it < 5; it++) begin
      load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 3), 13, 1'b1);
      chk($sformatf("rnd%0d_ready", it), key_ready, 1);
      active = 1'b0;
      idx = 0;
      for (int c = 0; c < 60 + NR + 1; c++) begin
        if (c < 60) begin
          st = ($urandom_range(0, 7) == 0);
          nx = $urandom_range(0, 1) == 1;
        end else begin
          st = 1'b0;
          nx = 1'b1;
        end
        rk_start = st;
        rk_next = nx;
        if (st) begin
          active = 1'b1;
          idx = NR;
        end else if (nx && active) begin
          if (idx > 0) idx--;
          else active = 1'b0;
        end
        tick();
        exp_out = active ? sched[idx] : '0;
        chk($sformatf("rnd%0d_%0d_vld", it, c), rk_out_vld, active);
        chk($sformatf("rnd%0d_%0d_out", it, c), rk_out, exp_out);
        chk($sformatf("rnd%0d_%0d_last", it, c), rk_out_last, active && idx == 0);
        chk($sformatf("rnd%0d_%0d_rdy", it, c), key_in_rdy, !active);
      end
      rk_start = 1'b0;
      rk_next = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
